vend_change_controller: RTL and testbench
=========================================

# vend_change_controller

Sequencing controller for the coin-operated vending datapath. Accepts single-cycle coin pulses (5/10/25 cents), accumulates credit, fires a one-cycle product-dispense pulse when credit reaches the price, then returns change one coin per cycle. It also rejects coins that arrive while it is busy or that would overflow the credit register. Sits between the coin acceptor front end and the product/coin-return actuators.

## Interface
Parameters:
- PRICE, 25: product price in cents; multiple of 5, range 5..MAX_CREDIT.
- MAX_CREDIT, 95: highest credit held; multiple of 5; must fit in CREDIT_W.
- CREDIT_W, 7: credit register width in bits.

Ports:
- clock  in  1  single clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- fiveCents  in  1  nickel inserted; one-cycle pulse.
- tenCents  in  1  dime inserted; one-cycle pulse.
- twentyFiveCents  in  1  quarter inserted; one-cycle pulse.
- cancel  in  1  refund request; present only with VEND_CANCEL_EN.
- theProduct  out  1  dispense pulse; high exactly one cycle per vend.
- returnQuarter / returnDime / returnNickel  out  1 each  change-coin pulses; at most one high per cycle.
- coinReject  out  1  one-cycle pulse; a coin was refused on the previous edge.
- busy  out  1  high in VEND or CHANGE.
- credit  out  CREDIT_W  current credit in cents.

## Operation
- States: IDLE, VEND, CHANGE. The state register and credit register are the only stored values besides coinReject.
- theProduct, busy and return* are Moore outputs decoded from state and credit. coinReject is registered.
- IDLE, no coin: hold.
- IDLE, coin: the coin value v is the largest asserted input.
  - If more than one input is asserted, accept only v and set coinReject.
  - If credit+v > MAX_CREDIT, reject the coin (coinReject=1) and leave credit unchanged.
  - If credit+v >= PRICE: credit <= credit+v-PRICE, go to VEND.
  - Otherwise: credit <= credit+v, stay in IDLE.
- VEND: theProduct=1. Next state is CHANGE if credit>0, else IDLE.
- CHANGE: emit the largest coin <= credit and subtract it.
  - returnQuarter if credit>=25; else returnDime if credit>=10; else returnNickel.
  - Go to IDLE on the edge where credit becomes 0.
- Any coin in VEND or CHANGE is rejected (coinReject=1 next cycle) and credit is unaffected.
- Arithmetic is unsigned, CREDIT_W bits. Credit never exceeds MAX_CREDIT and never goes below 0. Credit is always a multiple of 5.

## Timing
- Reset values: state=IDLE, credit=0, theProduct=0, return*=0, coinReject=0, busy=0, visible after the reset edge.
- Reset mid-VEND or mid-CHANGE: pending product and change are abandoned; all outputs are 0 in the cycle after the reset edge.
- Coin at edge N reaching PRICE: theProduct high in cycle N+1. Change pulses follow in cycles N+2 .. N+1+k, where k is the greedy coin count. busy drops in cycle N+2+k.
- Coin at edge N below PRICE: credit shows the new value in cycle N+1.
- coinReject is high in the cycle after the offending edge only.
- Inputs are sampled only at rising edges. A coin held high for m cycles counts as m coins.

## Configuration
- VEND_CANCEL_EN defined: the cancel port exists.
  - cancel in IDLE with credit>0: go to CHANGE and refund the full credit without vending.
  - cancel and a coin on the same edge: cancel wins and the coin is rejected (coinReject=1).
  - cancel with credit=0, or outside IDLE: ignored.
- VEND_CANCEL_EN undefined: no cancel port. Credit is held until a vend or a reset.

## Test plan
- Reset, then dime, nickel, dime on consecutive edges (PRICE=25) -> credit 10, 15, then theProduct for one cycle, credit 0, back to IDLE with no return pulses.
- Credit 20, then quarter -> credit 45 exceeds price by 20: theProduct one cycle, then returnDime, returnDime on the next two cycles, busy low afterwards.
- fiveCents and twentyFiveCents on the same edge from credit 0 -> credit 25 accepted, theProduct next cycle, coinReject high in that same cycle.
- Credit 90 (PRICE=95, MAX_CREDIT=95), then dime -> coinReject=1, credit stays 90; a following nickel -> theProduct, no change.
- Coin during CHANGE -> coinReject pulse; change sequence and final credit are unaffected. Reset asserted mid-CHANGE -> all outputs 0 and credit=0 the next cycle.
- With VEND_CANCEL_EN: credit 15, then cancel -> returnDime, returnNickel on consecutive cycles, theProduct never asserted, credit 0.

Source files
------------

// File: rtl/vend_change_controller.sv
// vend_change_controller
//
// Sequencing controller for the coin-operated vending datapath. It accumulates
// nickel/dime/quarter credit and fires a one-cycle dispense pulse when the
// credit reaches PRICE. It then pays back the excess one coin per cycle,
// always choosing the largest coin that fits.
//
// Coins are refused, with a one-cycle coinReject pulse, in three cases:
// when they arrive while a vend or change sequence is running, when they
// would push credit above MAX_CREDIT, or when several coin inputs are high on
// the same edge. In the last case the largest coin is still accepted.
//
// Parameters:
//   PRICE      product price in cents (multiple of 5, 5..MAX_CREDIT)
//   MAX_CREDIT highest credit ever held (multiple of 5)
//   CREDIT_W   credit register width; must hold MAX_CREDIT
//
// Ports:
//   clock            single clock, rising edge
//   reset            synchronous, active-high
//   fiveCents        nickel inserted (one-cycle pulse)
//   tenCents         dime inserted (one-cycle pulse)
//   twentyFiveCents  quarter inserted (one-cycle pulse)
//   cancel           refund request (only when VEND_CANCEL_EN is defined)
//   theProduct       dispense pulse, high for the single VEND cycle
//   returnQuarter    change coin pulses; at most one is high per cycle
//   returnDime
//   returnNickel
//   coinReject       a coin was refused on the previous edge
//   busy             a vend or change sequence is in progress
//   credit           current credit in cents
//
// Optional feature macro: VEND_CANCEL_EN. When it is defined, the cancel port
// exists. Asserting cancel in IDLE with non-zero credit refunds the whole
// credit through the CHANGE sequence without vending.

module vend_change_controller #(
  parameter int PRICE      = 25,
  parameter int MAX_CREDIT = 95,
  parameter int CREDIT_W   = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                fiveCents,
  input  logic                tenCents,
  input  logic                twentyFiveCents,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  output logic                theProduct,
  output logic                returnQuarter,
  output logic                returnDime,
  output logic                returnNickel,
  output logic                coinReject,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VEND   = 2'd1,
    CHANGE = 2'd2
  } state_t;

  // Coin values at register width, plus price and limit at width+1. The
  // extra bit lets credit+coin be formed without wrapping.
  localparam logic [CREDIT_W-1:0] C5      = CREDIT_W'(5);
  localparam logic [CREDIT_W-1:0] C10     = CREDIT_W'(10);
  localparam logic [CREDIT_W-1:0] C25     = CREDIT_W'(25);
  localparam logic [CREDIT_W:0]   PRICE_W = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0]   MAX_W   = (CREDIT_W+1)'(MAX_CREDIT);

  state_t              state;
  logic                coin_any;
  logic                coin_multi;
  logic [CREDIT_W-1:0] coin_val;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] change_val;
  logic                cancel_req;

  // Several simultaneous coins: the largest one wins and the rest are
  // reported through coinReject.
  assign coin_any   = fiveCents | tenCents | twentyFiveCents;
  assign coin_multi = (fiveCents & tenCents) | (fiveCents & twentyFiveCents)
                    | (tenCents & twentyFiveCents);
  assign coin_val   = twentyFiveCents ? C25 : (tenCents ? C10 : C5);
  assign sum        = {1'b0, credit} + {1'b0, coin_val};

  // Greedy change: the largest coin not exceeding the remaining credit.
  // Credit is always a non-zero multiple of 5 while in CHANGE, so a nickel is
  // the correct fallback.
  assign change_val = (credit >= C25) ? C25 : ((credit >= C10) ? C10 : C5);

`ifdef VEND_CANCEL_EN
  // A cancel with nothing to refund is ignored, so a coin on that edge is
  // processed normally.
  assign cancel_req = cancel && (credit != '0);
`else
  assign cancel_req = 1'b0;
`endif

  // NOTE: all stored values use non-blocking assignments. Every branch then
  // reads the pre-edge state and credit, whatever order the statements run in.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      credit     <= '0;
      coinReject <= 1'b0;
    end else begin
      coinReject <= 1'b0;
      case (state)
        IDLE: begin
          if (cancel_req) begin
            // Refund the whole credit. Any coin on this edge is refused.
            state      <= CHANGE;
            coinReject <= coin_any;
          end else if (coin_any) begin
            if (sum > MAX_W) begin
              coinReject <= 1'b1;
            end else begin
              coinReject <= coin_multi;
              if (sum >= PRICE_W) begin
                credit <= CREDIT_W'(sum - PRICE_W);
                state  <= VEND;
              end else begin
                credit <= sum[CREDIT_W-1:0];
              end
            end
          end
        end
        VEND: begin
          coinReject <= coin_any;
          state      <= (credit != '0) ? CHANGE : IDLE;
        end
        CHANGE: begin
          coinReject <= coin_any;
          credit     <= credit - change_val;
          if (credit == change_val) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore outputs, decoded only from the state and credit registers.
  assign theProduct    = (state == VEND);
  assign busy          = (state != IDLE);
  assign returnQuarter = (state == CHANGE) && (credit >= C25);
  assign returnDime    = (state == CHANGE) && (credit <  C25) && (credit >= C10);
  assign returnNickel  = (state == CHANGE) && (credit <  C10);

endmodule

// File: tb/tb_vend_change_controller.sv
// tb_vend_change_controller
//
// Bench for vend_change_controller. It builds two instances:
//   dut_a  PRICE=25, MAX_CREDIT=95  (main vend/change behaviour, cancel)
//   dut_b  PRICE=95, MAX_CREDIT=95  (credit-limit boundary)
//
// A transaction-level model runs beside the instances. When a vend or a
// refund starts, the model lays out the whole output sequence ahead of time:
// one dispense cycle, then one greedy change coin per cycle. It then plays
// that sequence back one cycle at a time.
//
// On every falling edge after the first reset, the model's outputs are
// compared against both instances. Directed sequences also pin
// hand-computed literal outputs.
//
// The cancel scenarios are built only when VEND_CANCEL_EN is defined.

module tb_vend_change_controller;

  localparam int CW      = 7;
  localparam int PRICE_A = 25;
  localparam int MAX_A   = 95;
  localparam int PRICE_B = 95;
  localparam int MAX_B   = 95;

  logic          clock = 1'b0;
  logic          reset;
  logic          five_a, ten_a, quarter_a, cancel_a;
  logic          five_b, ten_b, quarter_b;
  logic          prod_a, rq_a, rd_a, rn_a, rej_a, busy_a;
  logic          prod_b, rq_b, rd_b, rn_b, rej_b, busy_b;
  logic [CW-1:0] credit_a, credit_b;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  vend_change_controller #(.PRICE(PRICE_A), .MAX_CREDIT(MAX_A), .CREDIT_W(CW)) dut_a (
    .clock           (clock),
    .reset           (reset),
    .fiveCents       (five_a),
    .tenCents        (ten_a),
    .twentyFiveCents (quarter_a),
`ifdef VEND_CANCEL_EN
    .cancel          (cancel_a),
`endif
    .theProduct      (prod_a),
    .returnQuarter   (rq_a),
    .returnDime      (rd_a),
    .returnNickel    (rn_a),
    .coinReject      (rej_a),
    .busy            (busy_a),
    .credit          (credit_a)
  );

  vend_change_controller #(.PRICE(PRICE_B), .MAX_CREDIT(MAX_B), .CREDIT_W(CW)) dut_b (
    .clock           (clock),
    .reset           (reset),
    .fiveCents       (five_b),
    .tenCents        (ten_b),
    .twentyFiveCents (quarter_b),
`ifdef VEND_CANCEL_EN
    .cancel          (1'b0),
`endif
    .theProduct      (prod_b),
    .returnQuarter   (rq_b),
    .returnDime      (rd_b),
    .returnNickel    (rn_b),
    .coinReject      (rej_b),
    .busy            (busy_b),
    .credit          (credit_b)
  );

  // ---------------------------------------------------------------------
  // Transaction-level model
  // ---------------------------------------------------------------------
  typedef struct packed {
    logic          prod;
    logic          rq;
    logic          rd;
    logic          rn;
    logic [CW-1:0] cr;
  } out_t;

  out_t pend    [2][16];
  int   cnt     [2];
  int   idle_cr [2];
  bit   rej_m   [2];
  bit   model_ok = 1'b0;

  task automatic push(input int k, input out_t e);
    pend[k][cnt[k]] = e;
    cnt[k]++;
  endtask

  // Plan the greedy change payout for `amt` cents, one coin per cycle.
  task automatic push_change(input int k, input int amt);
    int   rem;
    int   coin;
    out_t e;
    rem = amt;
    while (rem > 0) begin
      coin = (rem >= 25) ? 25 : ((rem >= 10) ? 10 : 5);
      e    = '0;
      e.rq = (coin == 25);
      e.rd = (coin == 10);
      e.rn = (coin == 5);
      e.cr = CW'(rem);
      push(k, e);
      rem -= coin;
    end
  endtask

  task automatic model_step(input int k, input int price, input int maxc,
                            input bit f, input bit t, input bit q,
                            input bit c, input bit rst);
    int   v;
    int   ch;
    bit   coin;
    out_t e;
    if (rst) begin
      cnt[k]     = 0;
      idle_cr[k] = 0;
      rej_m[k]   = 1'b0;
      return;
    end
    coin = f | t | q;
    if (cnt[k] > 0) begin
      // Busy: drop the cycle just shown and refuse any coin.
      for (int i = 0; i < cnt[k] - 1; i++) pend[k][i] = pend[k][i+1];
      cnt[k]--;
      rej_m[k] = coin;
    end else begin
      rej_m[k] = 1'b0;
      if (c && idle_cr[k] > 0) begin
        rej_m[k] = coin;
        push_change(k, idle_cr[k]);
        idle_cr[k] = 0;
      end else if (coin) begin
        v        = q ? 25 : (t ? 10 : 5);
        rej_m[k] = (int'(f) + int'(t) + int'(q)) > 1;
        if (idle_cr[k] + v > maxc) begin
          rej_m[k] = 1'b1;
        end else if (idle_cr[k] + v >= price) begin
          ch     = idle_cr[k] + v - price;
          e      = '0;
          e.prod = 1'b1;
          e.cr   = CW'(ch);
          push(k, e);
          push_change(k, ch);
          idle_cr[k] = 0;
        end else begin
          idle_cr[k] += v;
        end
      end
    end
  endtask

  // Output packing shared by the model, the DUT views and literal values:
  // {prod, rq, rd, rn, reject, busy, credit}.
  function automatic logic [31:0] model_vec(input int k);
    if (cnt[k] > 0)
      return {19'b0, pend[k][0].prod, pend[k][0].rq, pend[k][0].rd, pend[k][0].rn,
              rej_m[k], 1'b1, pend[k][0].cr};
    return {19'b0, 4'b0000, rej_m[k], 1'b0, CW'(idle_cr[k])};
  endfunction

  function automatic logic [31:0] lit(input int p, input int q, input int d,
                                      input int n, input int j, input int b,
                                      input int cr);
    return {19'b0, 1'(p), 1'(q), 1'(d), 1'(n), 1'(j), 1'(b), CW'(cr)};
  endfunction

  function automatic logic [31:0] vec_a();
    return {19'b0, prod_a, rq_a, rd_a, rn_a, rej_a, busy_a, credit_a};
  endfunction

  function automatic logic [31:0] vec_b();
    return {19'b0, prod_b, rq_b, rd_b, rn_b, rej_b, busy_b, credit_b};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got prod/rq/rd/rn/rej/busy=%b credit=%0d, want %b credit=%0d (t=%0t)",
               name, got[12:7], got[6:0], want[12:7], want[6:0], $time);
    end
  endtask

  // The model samples the same inputs the DUTs see at each rising edge.
  always @(posedge clock) begin
    model_step(0, PRICE_A, MAX_A, five_a, ten_a, quarter_a, cancel_a, reset);
    model_step(1, PRICE_B, MAX_B, five_b, ten_b, quarter_b, 1'b0, reset);
    if (reset) model_ok = 1'b1;
  end

  always @(negedge clock) begin
    if (model_ok) begin
      check("cycle_a", vec_a(), model_vec(0));
      check("cycle_b", vec_b(), model_vec(1));
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  // NOTE: inputs change 1 time unit after the rising edge. The DUT, the
  // model and the literal checks therefore all see stable values.
  task automatic edge_a(input bit f, input bit t, input bit q, input bit c);
    five_a = f; ten_a = t; quarter_a = q; cancel_a = c;
    @(posedge clock); #1;
    five_a = 1'b0; ten_a = 1'b0; quarter_a = 1'b0; cancel_a = 1'b0;
  endtask

  task automatic edge_b(input bit f, input bit t, input bit q);
    five_b = f; ten_b = t; quarter_b = q;
    @(posedge clock); #1;
    five_b = 1'b0; ten_b = 1'b0; quarter_b = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    five_a = 1'b0; ten_a = 1'b0; quarter_a = 1'b0; cancel_a = 1'b0;
    five_b = 1'b0; ten_b = 1'b0; quarter_b = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    check("reset_a", vec_a(), lit(0, 0, 0, 0, 0, 0, 0));
    check("reset_b", vec_b(), lit(0, 0, 0, 0, 0, 0, 0));

    // Dime, nickel, dime: 10, 15, then an exact vend with no change.
    edge_a(0, 1, 0, 0); check("t1_dime",    vec_a(), lit(0, 0, 0, 0, 0, 0, 10));
    edge_a(1, 0, 0, 0); check("t1_nickel",  vec_a(), lit(0, 0, 0, 0, 0, 0, 15));
    edge_a(0, 1, 0, 0); check("t1_vend",    vec_a(), lit(1, 0, 0, 0, 0, 1, 0));
    idle(1);            check("t1_idle",    vec_a(), lit(0, 0, 0, 0, 0, 0, 0));

    // Credit 20 plus a quarter: vend, then two dimes of change.
    edge_a(0, 1, 0, 0);
    edge_a(0, 1, 0, 0); check("t2_cr20",    vec_a(), lit(0, 0, 0, 0, 0, 0, 20));
    edge_a(0, 0, 1, 0); check("t2_vend",    vec_a(), lit(1, 0, 0, 0, 0, 1, 20));
    idle(1);            check("t2_dime1",   vec_a(), lit(0, 0, 1, 0, 0, 1, 20));
    idle(1);            check("t2_dime2",   vec_a(), lit(0, 0, 1, 0, 0, 1, 10));
    idle(1);            check("t2_done",    vec_a(), lit(0, 0, 0, 0, 0, 0, 0));

    // Nickel and quarter on one edge: the quarter vends and the reject flags.
    edge_a(1, 0, 1, 0); check("t3_multi",   vec_a(), lit(1, 0, 0, 0, 1, 1, 0));
    idle(1);            check("t3_after",   vec_a(), lit(0, 0, 0, 0, 0, 0, 0));

    // Limit boundary on dut_b: reach 90; a dime would give 100 > 95.
    edge_b(0, 0, 1); edge_b(0, 0, 1); edge_b(0, 0, 1);
    check("t4_cr75",    vec_b(), lit(0, 0, 0, 0, 0, 0, 75));
    edge_b(0, 1, 0); edge_b(1, 0, 0);
    check("t4_cr90",    vec_b(), lit(0, 0, 0, 0, 0, 0, 90));
    edge_b(0, 1, 0); check("t4_overflow", vec_b(), lit(0, 0, 0, 0, 1, 0, 90));
    edge_b(1, 0, 0); check("t4_vend",     vec_b(), lit(1, 0, 0, 0, 0, 1, 0));
    idle(1);         check("t4_idle",     vec_b(), lit(0, 0, 0, 0, 0, 0, 0));

    // Coin during CHANGE: refused, and the payout is unaffected.
    edge_a(0, 1, 0, 0); edge_a(0, 1, 0, 0); edge_a(0, 0, 1, 0);
    idle(1);            check("t5_change",  vec_a(), lit(0, 0, 1, 0, 0, 1, 20));
    edge_a(1, 0, 0, 0); check("t5_busyrej", vec_a(), lit(0, 0, 1, 0, 1, 1, 10));
    idle(1);            check("t5_done",    vec_a(), lit(0, 0, 0, 0, 0, 0, 0));

    // Reset in the middle of CHANGE abandons the payout.
    edge_a(0, 1, 0, 0); edge_a(0, 1, 0, 0); edge_a(0, 0, 1, 0);
    idle(1);            check("t6_change",  vec_a(), lit(0, 0, 1, 0, 0, 1, 20));
    do_reset();         check("t6_reset",   vec_a(), lit(0, 0, 0, 0, 0, 0, 0));

    // A nickel held high for three edges counts as three nickels.
    five_a = 1'b1;
    idle(3);
    five_a = 1'b0;
    check("t7_held",    vec_a(), lit(0, 0, 0, 0, 0, 0, 15));
    edge_a(0, 1, 0, 0); check("t7_vend",    vec_a(), lit(1, 0, 0, 0, 0, 1, 0));
    idle(2);

    // Coin arriving during the VEND cycle is refused.
    edge_a(0, 1, 0, 0); edge_a(0, 0, 1, 0);
    edge_a(0, 1, 0, 0); check("t8_vendrej", vec_a(), lit(0, 0, 1, 0, 1, 1, 10));
    idle(2);

`ifdef VEND_CANCEL_EN
    // Cancel with credit 15: dime then nickel refunded, no vend.
    edge_a(0, 1, 0, 0); edge_a(1, 0, 0, 0);
    edge_a(0, 0, 0, 1); check("c1_dime",    vec_a(), lit(0, 0, 1, 0, 0, 1, 15));
    idle(1);            check("c1_nickel",  vec_a(), lit(0, 0, 0, 1, 0, 1, 5));
    idle(1);            check("c1_done",    vec_a(), lit(0, 0, 0, 0, 0, 0, 0));
    // Cancel and a coin on the same edge: cancel wins.
    edge_a(1, 0, 0, 0);
    edge_a(0, 1, 0, 1); check("c2_both",    vec_a(), lit(0, 0, 0, 1, 1, 1, 5));
    idle(1);            check("c2_done",    vec_a(), lit(0, 0, 0, 0, 0, 0, 0));
    // Cancel with zero credit is ignored; the coin is accepted.
    edge_a(0, 1, 0, 1); check("c3_ignored", vec_a(), lit(0, 0, 0, 0, 0, 0, 10));
    do_reset();
`endif

    // Mixed traffic checked only by the per-cycle model comparison.
    for (int i = 0; i < 12; i++) begin
      edge_a(i % 3 == 0, i % 4 == 1, i % 5 == 2, 1'b0);
      edge_b(i % 2 == 0, i % 3 == 1, i % 4 == 3);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
